cic_out_framer: RTL

//  Consumes decimated 51-bit output of the 3rd-order CIC decimator; rounds, scales and saturates to OUT_W bits.

---
 rtl/cic_out_framer_if.sv | 30 +++
 rtl/cic_out_framer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/cic_out_framer_if.sv
// Sample-in / byte-out bundle for the CIC output framer.
// The master side is the framer: it takes samples in and drives the byte stream out.
interface cic_out_framer_if #(
  parameter int unsigned IN_W = 51
);
  logic            clk_enable;
  logic [IN_W-1:0] din;
  logic            din_valid;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic            tx_ready;

  modport master (
    input  clk_enable,
    input  din,
    input  din_valid,
    input  tx_ready,
    output tx_data,
    output tx_valid
  );

  modport slave (
    output clk_enable,
    output din,
    output din_valid,
    output tx_ready,
    input  tx_data,
    input  tx_valid
  );
endinterface

// File: rtl/cic_out_framer.sv
// Rounds, scales and saturates decimated CIC samples, queues them, and serialises
// each one as a header byte followed by big-endian two's-complement data bytes.
module cic_out_framer #(
  parameter int unsigned  IN_W  = 51,
  parameter int unsigned  OUT_W = 24,
  parameter int unsigned  SHIFT = 27,
  parameter int unsigned  DEPTH = 8,
  parameter logic [7:0]   HDR   = 8'hA5,
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  cic_out_framer_if.master  bus,
  output logic [LVL_W-1:0]  o_fifo_level,
  output logic              o_overflow
);

  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned NB     = OUT_W / 8;
  localparam int unsigned CNT_W  = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [IN_W:0] RND  = (SHIFT > 0) ? ((IN_W+1)'(1) << RND_SH) : '0;

  typedef enum logic [1:0] {S_IDLE, S_HEAD, S_DATA} state_t;

  logic signed [IN_W:0] w_sum;
  logic signed [IN_W:0] w_q;
  logic                 w_out_of_range;
  logic [OUT_W-1:0]     w_sat;

  logic                 r_s_valid;
  logic [OUT_W-1:0]     r_s_data;

  logic [OUT_W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [LVL_W-1:0]     r_level;
  logic                 r_overflow;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [OUT_W-1:0]     r_shift;
  logic [OUT_W-1:0]     w_shift_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [7:0]           r_tx_data;
  logic [7:0]           w_tx_data_nxt;
  logic                 r_tx_valid;
  logic                 w_tx_valid_nxt;
  logic                 w_acc;

  // Round half-up at one extra bit of headroom, then arithmetic shift.
  assign w_sum = $signed({bus.din[IN_W-1], bus.din}) + $signed(RND);
  assign w_q   = w_sum >>> SHIFT;

  // In range only when every bit above the output sign bit matches it.
  assign w_out_of_range = !((&w_q[IN_W:OUT_W-1]) || !(|w_q[IN_W:OUT_W-1]));
  assign w_sat = !w_out_of_range ? w_q[OUT_W-1:0] :
                 (w_q[IN_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}});

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s_valid <= 1'b0;
      r_s_data  <= '0;
    end else begin
      r_s_valid <= bus.clk_enable & bus.din_valid;
      if (bus.clk_enable & bus.din_valid) r_s_data <= w_sat;
    end
  end

  // A full FIFO still accepts a push when the serialiser pops in the same cycle.
  assign w_full  = (r_level == LVL_W'(DEPTH));
  assign w_empty = (r_level == '0);
  assign w_push  = r_s_valid & (!w_full | w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= r_s_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_level <= r_level + LVL_W'(1);
      else if (!w_push && w_pop) r_level <= r_level - LVL_W'(1);
      if (r_s_valid && !w_push)  r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_cnt      <= w_cnt_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_valid <= w_tx_valid_nxt;
    end
  end

  assign w_acc = r_tx_valid & bus.tx_ready;

  // r_cnt holds the number of data bytes still to load after the one on tx_data.
  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_cnt_nxt      = r_cnt;
    w_tx_data_nxt  = r_tx_data;
    w_tx_valid_nxt = r_tx_valid;
    w_pop          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop          = 1'b1;
          w_shift_nxt    = r_mem[r_rd_ptr];
          w_tx_data_nxt  = HDR;
          w_tx_valid_nxt = 1'b1;
          w_state_nxt    = S_HEAD;
        end
      end
      S_HEAD: begin
        if (w_acc) begin
          w_tx_data_nxt = r_shift[OUT_W-1 -: 8];
          w_shift_nxt   = r_shift << 8;
          w_cnt_nxt     = CNT_W'(NB - 1);
          w_state_nxt   = S_DATA;
        end
      end
      S_DATA: begin
        if (w_acc) begin
          if (r_cnt != '0) begin
            w_tx_data_nxt = r_shift[OUT_W-1 -: 8];
            w_shift_nxt   = r_shift << 8;
            w_cnt_nxt     = r_cnt - CNT_W'(1);
          end else if (!w_empty) begin
            w_pop         = 1'b1;
            w_shift_nxt   = r_mem[r_rd_ptr];
            w_tx_data_nxt = HDR;
            w_state_nxt   = S_HEAD;
          end else begin
            w_tx_valid_nxt = 1'b0;
            w_state_nxt    = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.tx_data   = r_tx_data;
  assign bus.tx_valid  = r_tx_valid;
  assign o_fifo_level  = r_level;
  assign o_overflow    = r_overflow;

endmodule
